// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the RV32I execution controller.
// Holds the run-mode encoding that appears on the controller's `state`
// output and is decoded by the seven-segment driver.
package cpu_ctrl_pkg;

  // Width of the run-mode encoding
  localparam int STATE_W = 2;

  // Run modes as they appear on the controller's `state` output
  typedef enum logic [STATE_W-1:0] {
    ST_HALT  = 2'd0,
    ST_STEP  = 2'd1,
    ST_RUN   = 2'd2,
    ST_BREAK = 2'd3
  } state_t;

endpackage

// File: rtl/ce_divider.sv
// Modulo-DIV phase counter used to pace slow-run mode.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   clr   - synchronous clear; the count restarts at 0 on the next cycle
//   tick  - high while the count is 0, i.e. once every DIV cycles
module ce_divider #(
  parameter int DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  // Free-running 0..DIV-1 counter; a clear forces phase 0 so the next cycle
  // produces a tick, which is how a fresh slow-run gets its first pulse
  // immediately instead of waiting out a stale phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == '0);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Execution controller for the RV32I core: turns debounced button pulses into
// the core clock-enable, with halt / single-step / free-run / slow-run modes,
// one PC breakpoint and a counter of enabled (retired) cycles.
// Ports:
//   clk, rst_n        - system clock, asynchronous active-low reset
//   key_run/step/halt - one-cycle debounced button pulses (halt > step > run)
//   sw_slow           - level; selects slow-run pacing while running
//   bp_en, bp_addr    - breakpoint enable and PC
//   pc                - core's current PC
//   cpu_ce            - core clock-enable
//   state             - current mode (HALT/STEP/RUN/BREAK)
//   bp_hit            - high while stopped at the breakpoint
//   ce_cnt            - number of cycles with cpu_ce high (wraps)
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int SLOW_DIV    = 50_000_000,
  parameter int STEP_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_run,
  input  logic               key_step,
  input  logic               key_halt,
  input  logic               sw_slow,
  input  logic               bp_en,
  input  logic [31:0]        bp_addr,
  input  logic [31:0]        pc,
  output logic               cpu_ce,
  output logic [STATE_W-1:0] state,
  output logic               bp_hit,
  output logic [CNT_W-1:0]   ce_cnt
);

  localparam int                STEP_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

  state_t              state_q;
  state_t              state_next;
  logic [STEP_W-1:0]   step_cnt;
  logic [STEP_W-1:0]   step_cnt_next;
  logic                skip;
  logic                sw_slow_q;
  logic                ce_q;
  logic                bp_block;
  logic                tick;
  logic                enter_run;
  logic                clr_cnt;
  logic                div_clr;

  // Slow-run phase restarts whenever RUN is (re)entered or the slow switch
  // changes level, so the user always sees a pulse right after the action.
  assign div_clr = enter_run | (sw_slow ^ sw_slow_q);

  ce_divider #(
    .DIV (SLOW_DIV)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (div_clr),
    .tick  (tick)
  );

  // Enable request comes straight from the registered mode, so a reset or a
  // halt removes the enable without waiting for another edge. The breakpoint
  // comparison is combinational so the matching instruction is withheld in
  // the very cycle its PC appears; the skip flag lets the first instruction
  // after (re)entering RUN through even if it sits on the breakpoint.
  always_comb begin
    ce_q          = 1'b0;
    bp_block      = 1'b0;
    state_next    = state_q;
    step_cnt_next = step_cnt;
    enter_run     = 1'b0;
    clr_cnt       = 1'b0;

    case (state_q)
      ST_STEP: ce_q = 1'b1;
      ST_RUN:  ce_q = sw_slow ? tick : 1'b1;
      default: ce_q = 1'b0;
    endcase

    bp_block = bp_en & (pc == bp_addr) & ~skip & (state_q == ST_RUN);

    case (state_q)
      ST_HALT: begin
        if (key_halt) begin
          clr_cnt = 1'b1;
        end else if (key_step) begin
          state_next    = ST_STEP;
          step_cnt_next = '0;
        end else if (key_run) begin
          state_next = ST_RUN;
          enter_run  = 1'b1;
        end
      end
      ST_STEP: begin
        if (key_halt || step_cnt == STEP_LAST) begin
          state_next    = ST_HALT;
          step_cnt_next = '0;
        end else begin
          step_cnt_next = step_cnt + STEP_W'(1);
        end
      end
      ST_RUN: begin
        if (key_halt) begin
          state_next = ST_HALT;
        end else if (bp_block && ce_q) begin
          state_next = ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (key_halt) begin
          state_next = ST_HALT;
        end else if (key_step) begin
          state_next    = ST_STEP;
          step_cnt_next = '0;
        end else if (key_run) begin
          state_next = ST_RUN;
          enter_run  = 1'b1;
        end
      end
      default: state_next = ST_HALT;
    endcase
  end

  // Mode, step progress, breakpoint skip and the retired-cycle counter.
  // Skip is armed on every RUN entry and consumed by the first enabled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_HALT;
      step_cnt  <= '0;
      skip      <= 1'b0;
      sw_slow_q <= 1'b0;
      ce_cnt    <= '0;
    end else begin
      state_q   <= state_next;
      step_cnt  <= step_cnt_next;
      sw_slow_q <= sw_slow;
      if (enter_run) begin
        skip <= 1'b1;
      end else if (cpu_ce) begin
        skip <= 1'b0;
      end
      if (clr_cnt) begin
        ce_cnt <= '0;
      end else if (cpu_ce) begin
        ce_cnt <= ce_cnt + CNT_W'(1);
      end
    end
  end

  assign cpu_ce = ce_q & ~bp_block;
  assign state  = state_q;
  assign bp_hit = (state_q == ST_BREAK);

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl. Two instances share all inputs: dut_a has
// STEP_CYCLES=1, dut_b has STEP_CYCLES=5; both use SLOW_DIV=4. Each cycle the
// expected outputs for that cycle are queued when the inputs are driven and
// popped and compared once the DUT outputs have settled.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_run = 1'b0;
  logic        key_step = 1'b0;
  logic        key_halt = 1'b0;
  logic        sw_slow = 1'b0;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = 32'h0;
  logic [31:0] pc = 32'h0;

  logic        a_cpu_ce, b_cpu_ce;
  logic [1:0]  a_state, b_state;
  logic        a_bp_hit, b_bp_hit;
  logic [15:0] a_ce_cnt, b_ce_cnt;

  int errors = 0;
  int checks = 0;

  string       tag_q[$];
  logic [19:0] exp_q[$];
  bit          sel_q[$];

  // 100 MHz clock
  always #5 clk = ~clk;

  cpu_run_ctrl #(.SLOW_DIV(4), .STEP_CYCLES(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .key_run(key_run), .key_step(key_step),
    .key_halt(key_halt), .sw_slow(sw_slow), .bp_en(bp_en), .bp_addr(bp_addr),
    .pc(pc), .cpu_ce(a_cpu_ce), .state(a_state), .bp_hit(a_bp_hit),
    .ce_cnt(a_ce_cnt)
  );

  cpu_run_ctrl #(.SLOW_DIV(4), .STEP_CYCLES(5), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .key_run(key_run), .key_step(key_step),
    .key_halt(key_halt), .sw_slow(sw_slow), .bp_en(bp_en), .bp_addr(bp_addr),
    .pc(pc), .cpu_ce(b_cpu_ce), .state(b_state), .bp_hit(b_bp_hit),
    .ce_cnt(b_ce_cnt)
  );

  // Drive one cycle's inputs at the falling edge and queue what the selected
  // instance must show during that same cycle; bp_hit is expected exactly
  // when the expected mode is BREAK.
  task automatic applyStimulus(input int sel, input int rn, input int r, input int s,
                               input int h, input int sl, input logic [31:0] pcv,
                               input int e_ce, input int e_st, input int e_cnt,
                               input string tag);
    logic [1:0] st;
    @(negedge clk);
    rst_n    = (rn != 0);
    key_run  = (r != 0);
    key_step = (s != 0);
    key_halt = (h != 0);
    sw_slow  = (sl != 0);
    pc       = pcv;
    st = 2'(e_st);
    exp_q.push_back({(e_ce != 0), st, (st == 2'd3), 16'(e_cnt)});
    tag_q.push_back(tag);
    sel_q.push_back(sel != 0);
  endtask

  // Let combinational outputs settle, then drain the scoreboard against the
  // instance each entry names.
  task automatic checkOutput();
    logic [19:0] exp;
    logic [19:0] obs;
    string       tag;
    bit          sel;
    #1;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      tag = tag_q.pop_front();
      sel = sel_q.pop_front();
      obs = sel ? {b_cpu_ce, b_state, b_bp_hit, b_ce_cnt}
                : {a_cpu_ce, a_state, a_bp_hit, a_ce_cnt};
      checks++;
      assert (obs === exp) else begin
        errors++;
        $error("[TB] FAIL %s: observed ce=%b state=%0d bp_hit=%b ce_cnt=%0d, required ce=%b state=%0d bp_hit=%b ce_cnt=%0d",
               tag, obs[19], obs[18:17], obs[16], obs[15:0],
               exp[19], exp[18:17], exp[16], exp[15:0]);
      end
    end
  endtask

  task automatic doCycle(input int sel, input int rn, input int r, input int s,
                         input int h, input int sl, input logic [31:0] pcv,
                         input int e_ce, input int e_st, input int e_cnt,
                         input string tag);
    applyStimulus(sel, rn, r, s, h, sl, pcv, e_ce, e_st, e_cnt, tag);
    checkOutput();
  endtask

  // Directed sequence: reset, step, fast run, breakpoint, slow run, key
  // priority, asynchronous reset, then multi-cycle step on dut_b.
  initial begin
    $display("[TB] cpu_run_ctrl bench start");

    doCycle(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, "reset_a");
    doCycle(1, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, "reset_b");
    doCycle(0, 1, 0, 0, 0, 0, 32'h0, 0, 0, 0, "post_reset");

    // Single step, one enable cycle
    doCycle(0, 1, 0, 1, 0, 0, 32'h0, 0, 0, 0, "step_press");
    doCycle(0, 1, 0, 0, 0, 0, 32'h0, 1, 1, 0, "step_ce");
    doCycle(0, 1, 0, 0, 0, 0, 32'h0, 0, 0, 1, "step_done");
    doCycle(0, 1, 0, 0, 0, 0, 32'h0, 0, 0, 1, "step_idle");

    // Fast run for ten cycles, then halt and clear the counter
    doCycle(0, 1, 0, 0, 1, 0, 32'h0, 0, 0, 1, "halt_clear_press");
    doCycle(0, 1, 1, 0, 0, 0, 32'h0, 0, 0, 0, "run_press");
    for (int i = 1; i <= 10; i++)
      doCycle(0, 1, 0, 0, (i == 10), 0, 32'h0, 1, 2, i - 1, "run_fast");
    doCycle(0, 1, 0, 0, 1, 0, 32'h0, 0, 0, 10, "run_halted");
    doCycle(0, 1, 0, 0, 0, 0, 32'h0, 0, 0, 0, "cnt_cleared");

    // Breakpoint at 0x10 with the PC walking upward
    bp_en   = 1'b1;
    bp_addr = 32'h10;
    doCycle(0, 1, 1, 0, 0, 0, 32'h0, 0, 0, 0, "bp_run_press");
    for (int i = 0; i < 4; i++)
      doCycle(0, 1, 0, 0, 0, 0, 32'(i * 4), 1, 2, i, "bp_run");
    doCycle(0, 1, 0, 0, 0, 0, 32'h10, 0, 2, 4, "bp_block");
    doCycle(0, 1, 0, 0, 0, 0, 32'h10, 0, 3, 4, "bp_break");
    doCycle(0, 1, 1, 0, 0, 0, 32'h10, 0, 3, 4, "bp_resume_press");
    doCycle(0, 1, 0, 0, 0, 0, 32'h10, 1, 2, 4, "bp_skip_exec");
    doCycle(0, 1, 0, 0, 0, 0, 32'h14, 1, 2, 5, "bp_continue_14");
    doCycle(0, 1, 0, 0, 0, 0, 32'h18, 1, 2, 6, "bp_continue_18");
    doCycle(0, 1, 0, 0, 1, 0, 32'h1C, 1, 2, 7, "bp_halt_press");
    doCycle(0, 1, 0, 0, 0, 0, 32'h20, 0, 0, 8, "bp_halted");
    bp_en = 1'b0;

    // Slow run: pulses at k+1, k+5, k+9; then a switch toggle re-phases it
    doCycle(0, 1, 0, 0, 1, 1, 32'h0, 0, 0, 8, "slow_clear_press");
    doCycle(0, 1, 1, 0, 0, 1, 32'h0, 0, 0, 0, "slow_run_press");
    for (int i = 1; i <= 12; i++)
      doCycle(0, 1, 0, 0, 0, 1, 32'h0, ((i - 1) % 4 == 0), 2, (i + 2) / 4, "slow_run");
    doCycle(0, 1, 0, 0, 0, 0, 32'h0, 1, 2, 3, "slow_off_a");
    doCycle(0, 1, 0, 0, 0, 0, 32'h0, 1, 2, 4, "slow_off_b");
    doCycle(0, 1, 0, 0, 0, 1, 32'h0, 0, 2, 5, "slow_on_again");
    for (int j = 1; j <= 6; j++)
      doCycle(0, 1, 0, 0, (j == 6), 1, 32'h0, ((j - 1) % 4 == 0), 2, 5 + (j + 2) / 4,
              "slow_rephase");
    doCycle(0, 1, 0, 0, 0, 0, 32'h0, 0, 0, 7, "slow_halted");

    // Key priority
    doCycle(0, 1, 1, 1, 0, 0, 32'h0, 0, 0, 7, "prio_run_step_press");
    doCycle(0, 1, 0, 0, 0, 0, 32'h0, 1, 1, 7, "prio_step_taken");
    doCycle(0, 1, 0, 0, 0, 0, 32'h0, 0, 0, 8, "prio_step_done");
    doCycle(0, 1, 0, 1, 1, 0, 32'h0, 0, 0, 8, "prio_halt_step_press");
    doCycle(0, 1, 0, 0, 0, 0, 32'h0, 0, 0, 0, "prio_halt_clears");
    doCycle(0, 1, 0, 0, 0, 0, 32'h0, 0, 0, 0, "prio_still_halt");

    // Asynchronous reset in the middle of a run
    doCycle(0, 1, 1, 0, 0, 0, 32'h0, 0, 0, 0, "rst_run_press");
    for (int i = 0; i < 3; i++)
      doCycle(0, 1, 0, 0, 0, 0, 32'h0, 1, 2, i, "rst_running");
    doCycle(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, "rst_async_a");
    doCycle(1, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, "rst_async_b");
    doCycle(1, 1, 0, 0, 0, 0, 32'h0, 0, 0, 0, "rst_release_b");

    // Five-cycle step: aborted in its 2nd cycle, then a full one that
    // ignores run/step pulses
    doCycle(1, 1, 0, 1, 0, 0, 32'h0, 0, 0, 0, "b_step_press");
    doCycle(1, 1, 0, 0, 0, 0, 32'h0, 1, 1, 0, "b_step_1");
    doCycle(1, 1, 0, 0, 1, 0, 32'h0, 1, 1, 1, "b_step_2_halt");
    doCycle(1, 1, 0, 0, 0, 0, 32'h0, 0, 0, 2, "b_aborted");
    doCycle(1, 1, 0, 1, 0, 0, 32'h0, 0, 0, 2, "b_step5_press");
    for (int i = 1; i <= 5; i++)
      doCycle(1, 1, (i == 2), (i == 3), 0, 0, 32'h0, 1, 1, 1 + i, "b_step5");
    doCycle(1, 1, 0, 0, 0, 0, 32'h0, 0, 0, 7, "b_step5_done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Execution controller for the Basys3 RV32I core. It takes the debounced one-cycle button pulses from the debouncers and produces the core's clock-enable. It provides four modes: halt, single-step, free-run and slow-run, plus a single PC breakpoint and a retired-cycle counter for the seven-segment display. It sits between the button debouncers and the core's `ce` input.

## Interface
Parameters:
- `SLOW_DIV`, 50_000_000: cycles between enable pulses in slow-run (2 Hz at 100 MHz); legal range ≥ 2.
- `STEP_CYCLES`, 1: number of consecutive enable cycles per step press; legal range ≥ 1.
- `CNT_W`, 16: width of the retired-cycle counter.

Ports:
- `clk`  in  1  100 MHz system clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `key_run`  in  1  debounced run pulse, 1 cycle.
- `key_step`  in  1  debounced step pulse, 1 cycle.
- `key_halt`  in  1  debounced halt pulse, 1 cycle.
- `sw_slow`  in  1  level: 1 selects slow-run while running.
- `bp_en`  in  1  breakpoint enable.
- `bp_addr`  in  32  breakpoint PC.
- `pc`  in  32  core's current PC.
- `cpu_ce`  out  1  core clock-enable.
- `state`  out  2  current mode: 0 HALT, 1 STEP, 2 RUN, 3 BREAK.
- `bp_hit`  out  1  high while in BREAK.
- `ce_cnt`  out  CNT_W  count of cycles with `cpu_ce`=1.

## Operation
- Reset values: `state`=HALT, `cpu_ce`=0, `bp_hit`=0, `ce_cnt`=0; step counter, divider counter and skip flag are 0.
- Key priority when pulses coincide: halt > step > run.
- HALT:
  - `cpu_ce`=0.
  - step → STEP; run → RUN.
  - halt while already in HALT clears `ce_cnt`.
- STEP:
  - `ce_q`=1 for exactly STEP_CYCLES cycles, then → HALT.
  - halt aborts: → HALT with `ce_q`=0 the next cycle.
  - run and step pulses are ignored.
- RUN:
  - `sw_slow`=0: `ce_q`=1 every cycle.
  - `sw_slow`=1: `ce_q`=1 only when the divider = 0. The divider counts 0..SLOW_DIV-1 and wraps.
  - The divider is cleared on entry to RUN and on any `sw_slow` edge.
  - halt → HALT. step is ignored.
- BREAK:
  - `cpu_ce`=0, `bp_hit`=1.
  - run → RUN; step → STEP; halt → HALT. Any exit clears `bp_hit`.
- Breakpoint rule:
  - `bp_block` = `bp_en` & (`pc`==`bp_addr`) & ~skip & (state==RUN). It is combinational.
  - `cpu_ce` = `ce_q` & ~`bp_block`. The instruction at `bp_addr` is therefore not executed.
  - When `bp_block` is high and `ce_q` is high, state → BREAK on that edge.
- Skip flag:
  - Set on every entry to RUN.
  - Cleared after the first cycle with `cpu_ce`=1, so resuming from a breakpoint executes it once.
  - STEP never checks the breakpoint.
- `ce_cnt` increments on every cycle with `cpu_ce`=1 and wraps at 2^CNT_W.

## Timing
- Key pulse sampled at edge k: new state and `ce_q` are valid after edge k; the first enable cycle is k+1.
- Step: `cpu_ce` is high in cycles k+1..k+STEP_CYCLES. `state` reads HALT from cycle k+STEP_CYCLES+1.
- Halt in RUN at edge k: `cpu_ce`=0 from cycle k+1.
- Breakpoint: `cpu_ce` drops in the same cycle `pc` matches; `state`=BREAK from the next cycle.
- Slow-run: first pulse in cycle k+1 after entry, then one pulse every SLOW_DIV cycles.
- Asynchronous reset mid-operation: `cpu_ce` drops immediately, with no partial step.

## Structure
- Package `cpu_ctrl_pkg`:
  - state encoding constants `ST_HALT`/`ST_STEP`/`ST_RUN`/`ST_BREAK`;
  - state width constant 2.
- Sub-module `ce_divider`:
  - parameterised modulo-SLOW_DIV counter with synchronous clear;
  - asserts `tick` when the count is 0.
- Everything else is one FSM and counter process in `cpu_run_ctrl`.

## Test plan
- Reset, then `key_step` pulse with STEP_CYCLES=1 → `cpu_ce` high exactly 1 cycle; `state` 0→1→0; `ce_cnt`=1.
- `key_run` with `sw_slow`=0, then `key_halt` 10 cycles later → 10 `cpu_ce` cycles; `ce_cnt`=10; another `key_halt` → `ce_cnt`=0.
- RUN, `bp_en`=1, `bp_addr`=0x10, `pc` driven 0x00,0x04,…:
  - at `pc`=0x10, `cpu_ce`=0 the same cycle; `state`=3 and `bp_hit`=1 next cycle;
  - `key_run` → one `cpu_ce` at 0x10, then the run continues.
- SLOW_DIV=4, `sw_slow`=1, `key_run` → `cpu_ce` pulses at cycles k+1, k+5, k+9. Toggling `sw_slow` restarts the phase.
- Simultaneous `key_run` + `key_step` in HALT → STEP. Simultaneous `key_halt` + `key_step` → stays HALT and clears `ce_cnt`.
- STEP_CYCLES=5, `key_halt` in the 2nd step cycle → `cpu_ce` low from the 3rd; `ce_cnt`=2. Asserting `rst_n` low mid-RUN → all outputs at reset values immediately.
